// File: rtl/ysyx_23060061_ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ysyx_23060061_ifu_prefetch
//
// Instruction fetch unit with a prefetch buffer. Sequential 32-bit
// instructions are fetched with AXI4 INCR read bursts and held, together
// with their PCs and a fault flag, in an internal FIFO. The IDU pops them
// one per valid/ready handshake. A redirect flushes the buffer and any
// in-flight burst, and fetch restarts at the new target.
//
// Ports
//   clk, rst               clock, synchronous active-low reset
//   redirect_valid/_pc     flush and restart fetch at redirect_pc (word aligned)
//   out_valid/out_ready    FIFO head handshake towards the IDU
//   out_inst/out_pc        instruction at the FIFO head and its PC
//   out_fault              that instruction was returned with rresp != 0
//   araddr/arvalid/arready AXI read address channel (arid/arlen/arsize/arburst)
//   rdata/rresp/rvalid     AXI read data channel (rready/rlast, rid ignored)
// -----------------------------------------------------------------------------
module ysyx_23060061_ifu_prefetch #(
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_fault,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    // Index width; a depth-1 buffer still uses a 2-entry ring so the
    // pointer arithmetic keeps a non-zero index width.
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned RD = 1 << AW;

    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] BURST_P = PW'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_DRAIN = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Registers
    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_saved_pc;
    logic          r_flush_pending;
    logic          r_burst_fault;
    logic [31:0]   r_araddr;
    logic [7:0]    r_arlen;
    logic          r_arvalid;
    logic          r_rready;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_rsv;
    logic [31:0]   r_mem_inst  [RD];
    logic [31:0]   r_mem_pc    [RD];
    logic          r_mem_fault [RD];

    // Next-state / control wires
    state_t        w_state_nxt;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   w_saved_pc_nxt;
    logic          w_flush_nxt;
    logic          w_bfault_nxt;
    logic [31:0]   w_araddr_nxt;
    logic [7:0]    w_arlen_nxt;
    logic          w_arvalid_nxt;
    logic          w_rready_nxt;
    logic          w_push;
    logic          w_issue;

    // Derived wires
    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_free;
    logic          w_can_issue;
    logic [12:0]   w_page_bytes;
    logic [10:0]   w_page_words;
    logic [4:0]    w_beats;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic          w_beat_fault;
    logic [31:0]   w_redirect_pc;
    logic          w_pop;
    logic          w_unused_ok;

    assign w_occ         = r_wptr - r_rptr;
    // Slots still promised to the burst in flight are not free.
    assign w_free        = DEPTH_P - w_occ - r_rsv;
    assign w_can_issue   = (w_free >= BURST_P);

    // Words left before the next 4 KB boundary clip the burst length.
    assign w_page_bytes  = 13'h1000 - {1'b0, r_fetch_pc[11:0]};
    assign w_page_words  = w_page_bytes[12:2];
    assign w_beats       = (w_page_words < 11'(BURST_LEN)) ? w_page_words[4:0] : 5'(BURST_LEN);

    assign w_ar_hs       = r_arvalid & arready;
    assign w_r_hs        = rvalid & r_rready;
    assign w_beat_fault  = (rresp != 2'b00);
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_pop         = out_valid & out_ready;

    assign w_unused_ok   = ^{rid, redirect_pc[1:0], w_page_bytes[1:0]};

    // AXI outputs
    assign araddr  = r_araddr;
    assign arvalid = r_arvalid;
    assign arlen   = r_arlen;
    assign rready  = r_rready;
    assign arid    = AXI_ID;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    // IDU outputs come straight from the registered FIFO head; zero when empty.
    assign out_valid = (w_occ != {PW{1'b0}});
    assign out_inst  = out_valid ? r_mem_inst[r_rptr[AW-1:0]]  : 32'd0;
    assign out_pc    = out_valid ? r_mem_pc[r_rptr[AW-1:0]]    : 32'd0;
    assign out_fault = out_valid ? r_mem_fault[r_rptr[AW-1:0]] : 1'b0;

    // Fetch FSM next-state and AXI control decode
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_saved_pc_nxt = r_saved_pc;
        w_flush_nxt    = r_flush_pending;
        w_bfault_nxt   = r_burst_fault;
        w_araddr_nxt   = r_araddr;
        w_arlen_nxt    = r_arlen;
        w_arvalid_nxt  = r_arvalid;
        w_rready_nxt   = r_rready;
        w_push         = 1'b0;
        w_issue        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                end else if (w_can_issue) begin
                    w_issue       = 1'b1;
                    w_state_nxt   = S_AR;
                    w_araddr_nxt  = r_fetch_pc;
                    w_arlen_nxt   = 8'(w_beats) - 8'd1;
                    w_arvalid_nxt = 1'b1;
                    w_bfault_nxt  = 1'b0;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end

            S_AR: begin
                // arvalid may not be withdrawn; remember the redirect instead.
                if (redirect_valid) begin
                    w_saved_pc_nxt = w_redirect_pc;
                    w_flush_nxt    = 1'b1;
                end else begin
                    w_flush_nxt    = r_flush_pending;
                end
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_flush_nxt   = 1'b0;
                    if (redirect_valid || r_flush_pending) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_state_nxt = S_R;
                    end
                end else begin
                    w_state_nxt = S_AR;
                end
            end

            S_R: begin
                if (redirect_valid) begin
                    // Beat in this cycle (if any) is dropped.
                    if (w_r_hs && rlast) begin
                        w_rready_nxt   = 1'b0;
                        w_fetch_pc_nxt = w_redirect_pc;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_saved_pc_nxt = w_redirect_pc;
                        w_state_nxt    = S_DRAIN;
                    end
                end else if (w_r_hs) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_bfault_nxt   = r_burst_fault | w_beat_fault;
                    if (rlast) begin
                        w_rready_nxt = 1'b0;
                        if (r_burst_fault || w_beat_fault) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_R;
                    end
                end else begin
                    w_state_nxt = S_R;
                end
            end

            S_DRAIN: begin
                if (redirect_valid) begin
                    w_saved_pc_nxt = w_redirect_pc;
                end else begin
                    w_saved_pc_nxt = r_saved_pc;
                end
                if (w_r_hs && rlast) begin
                    w_rready_nxt   = 1'b0;
                    w_state_nxt    = S_IDLE;
                    w_fetch_pc_nxt = redirect_valid ? w_redirect_pc : r_saved_pc;
                end else begin
                    w_state_nxt    = S_DRAIN;
                end
            end

            S_HALT: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_state_nxt    = S_HALT;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
            end
        endcase
    end

    // Fetch FSM state and AXI control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_fetch_pc      <= RESET_PC;
            r_saved_pc      <= RESET_PC;
            r_flush_pending <= 1'b0;
            r_burst_fault   <= 1'b0;
            r_araddr        <= 32'd0;
            r_arlen         <= 8'd0;
            r_arvalid       <= 1'b0;
            r_rready        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_fetch_pc      <= w_fetch_pc_nxt;
            r_saved_pc      <= w_saved_pc_nxt;
            r_flush_pending <= w_flush_nxt;
            r_burst_fault   <= w_bfault_nxt;
            r_araddr        <= w_araddr_nxt;
            r_arlen         <= w_arlen_nxt;
            r_arvalid       <= w_arvalid_nxt;
            r_rready        <= w_rready_nxt;
        end
    end

    // Reserved-slot count: claimed at issue, released per buffered beat,
    // dropped when a redirect abandons the burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsv <= {PW{1'b0}};
        end else if (redirect_valid) begin
            r_rsv <= {PW{1'b0}};
        end else if (w_issue) begin
            r_rsv <= PW'(w_beats);
        end else if (w_push) begin
            r_rsv <= r_rsv - {{(PW-1){1'b0}}, 1'b1};
        end else begin
            r_rsv <= r_rsv;
        end
    end

    // FIFO pointers; a redirect empties the buffer (a same-cycle pop was delivered).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
        end else if (redirect_valid) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
            end
        end
    end

    // FIFO storage write; contents are masked by out_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr[AW-1:0]]  <= rdata;
            r_mem_pc[r_wptr[AW-1:0]]    <= r_fetch_pc;
            r_mem_fault[r_wptr[AW-1:0]] <= w_beat_fault;
        end
    end

endmodule

// File: doc/ysyx_23060061_ifu_prefetch.md
Name: ysyx_23060061_ifu_prefetch

Overview:
- Parametrised next-generation instruction fetch unit.
- Issues AXI4 INCR read bursts of sequential 32-bit instructions and buffers them with their PCs in an internal FIFO.
- Presents instructions to the IDU through a valid/ready interface, one per handshake.
- Accepts a redirect (branch/jump/exception target) that flushes buffered and in-flight instructions.
- Sits between the PC/redirect logic and the AXI4 crossbar master port.

Parameters:
- BURST_LEN, 4, beats per AXI burst; power of 2, 1..16.
- FIFO_DEPTH, 8, instruction buffer entries; power of 2, >= BURST_LEN.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- AXI_ID, 4'd0, constant arid value.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits[1:0] are treated as 0
- out_valid  out  1  FIFO head valid
- out_ready  in  1  IDU accepts head
- out_inst  out  32  instruction at FIFO head
- out_pc  out  32  PC of out_inst
- out_fault  out  1  the fetch of this instruction returned rresp != 0
- araddr  out  32  burst start address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- arid  out  4  = AXI_ID
- arlen  out  8  beats-1
- arsize  out  3  fixed 3'b010
- arburst  out  2  fixed 2'b01 (INCR)
- rdata  in  32  read data
- rresp  in  2  read response
- rvalid  in  1  R valid
- rready  out  1  R ready
- rlast  in  1  last beat
- rid  in  4  ignored

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - arvalid=0, rready=0, out_valid=0, araddr=0, arlen=0, out_inst/out_pc/out_fault=0.
- State IDLE:
  - If free FIFO slots >= BURST_LEN and no redirect this cycle, go to AR next cycle.
  - In that same cycle, register araddr=fetch_pc, arlen=beats-1, and arvalid=1.
  - beats = min(BURST_LEN, (4096 - fetch_pc[11:0])/4), so a burst never crosses a 4 KB boundary.
- State AR:
  - Hold arvalid, araddr and arlen stable until arready.
  - On handshake: arvalid=0, rready=1, go to R.
  - A redirect during AR does not drop arvalid, as AXI requires. Set the flush_pending flag and go to DRAIN after the handshake.
- State R:
  - Each rvalid&&rready beat pushes {fetch_pc, rdata, rresp!=0} and then fetch_pc += 4.
  - The FIFO space is reserved at issue, so a beat is never refused.
  - On rlast: rready=0, then:
    - go to HALT if any beat of the burst faulted;
    - otherwise go to IDLE.
- State DRAIN:
  - rready=1; discard every beat until rlast.
  - Then rready=0, fetch_pc=saved redirect target, go to IDLE.
- State HALT:
  - No new AR is issued.
  - Buffered entries, including the faulting one, still drain to the IDU.
  - Only a redirect leaves HALT; it goes to IDLE.
- Redirect (redirect_valid=1 at posedge):
  - The FIFO is emptied and out_valid=0 next cycle.
  - In IDLE or HALT: fetch_pc=redirect_pc, go to IDLE.
  - In R: the beat arriving in the same cycle is discarded, the target is saved, go to DRAIN.
  - In AR or DRAIN: the target is saved; the latest redirect wins.
  - Earliest new arvalid is 2 cycles after the redirect edge (IDLE, then AR).
- Output side:
  - out_valid = FIFO not empty; out_* come from registered FIFO storage.
  - First out_valid is 1 cycle after the first R beat handshake.
  - A pop happens when out_valid&&out_ready.
  - Redirect and pop in the same cycle: the popped entry counts as delivered, the rest are flushed.
  - Push and pop in the same cycle when full: both succeed, so occupancy is unchanged.
- Occupancy, read/write pointers and reserved-slot count use log2(FIFO_DEPTH)+1 bits with wrap-around.
- Free slots = FIFO_DEPTH - occupancy - beats outstanding.
- fetch_pc wraps modulo 2^32.

Test Plan:
- Reset, out_ready=1, memory returns inst = address:
  - First AR has araddr=0x8000_0000, arlen=3, arsize=2, arburst=1.
  - out_pc sequence is 0x8000_0000, 0x8000_0004, and so on, with matching out_inst.
- out_ready=0 held, BURST_LEN=4, FIFO_DEPTH=8:
  - Exactly 2 bursts are issued.
  - No third AR while 8 entries are held.
  - The third AR follows the 4th pop.
- redirect_pc=0x8000_0FF8 from IDLE:
  - AR has arlen=1 (2 beats to the 4 KB boundary).
  - The next AR has araddr=0x8000_1000, arlen=3.
- Redirect to 0x8000_0100 during R after beat 2 of 4:
  - The remaining beats up to rlast are discarded and the FIFO is empty.
  - The next araddr is 0x8000_0100; no stale PC ever appears on out_pc.
- Redirect while arvalid=1 and arready=0 for 5 cycles:
  - arvalid and araddr stay stable.
  - That burst is fully drained and discarded, then fetch resumes at the new target.
- rresp=2'b10 on beat 3 (PC 0x8000_0008):
  - That entry has out_fault=1; beat 4 is buffered with out_fault=0.
  - No further AR until a redirect, after which fetch resumes normally.
